// File: rtl/rdy_vld_arb_pkg.sv
// rtl/rdy_vld_arb_pkg.sv - shared types, constants and helpers for the ready/valid FIFO arbiter
package rdy_vld_arb_pkg;

    typedef enum logic [0:0] {
        ARB_RR    = 1'b0,
        ARB_FIXED = 1'b1
    } arb_mode_e;

    localparam int CNT_W = 32;

    // Channel index width; never narrower than one bit
    function automatic int CH_W(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

endpackage

// File: rtl/rdy_vld_fifo_arb_if.sv
// rtl/rdy_vld_fifo_arb_if.sv - per-channel inputs and single tagged output of the FIFO arbiter
interface rdy_vld_fifo_arb_if
    import rdy_vld_arb_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int DATA_W = 32
) ();

    logic [N_CH-1:0]        in_vld;
    logic [N_CH-1:0]        in_rdy;
    logic [N_CH*DATA_W-1:0] in_data;
    logic                   out_vld;
    logic                   out_rdy;
    logic [DATA_W-1:0]      out_data;
    logic [CH_W(N_CH)-1:0]  out_ch;

    modport master (
        output in_vld, in_data, out_rdy,
        input  in_rdy, out_vld, out_data, out_ch
    );

    modport slave (
        input  in_vld, in_data, out_rdy,
        output in_rdy, out_vld, out_data, out_ch
    );

endinterface

// File: rtl/rdy_vld_chan_fifo.sv
// rtl/rdy_vld_chan_fifo.sv - single-channel synchronous FIFO, power-of-two depth
module rdy_vld_chan_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [DATA_W-1:0]      push_data,
    output logic [DATA_W-1:0]      head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    // Fullness comes from the start-of-cycle count, so a full FIFO refuses a push even while popping
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally at DEPTH; simultaneous push and pop leaves count unchanged
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: a slot is only read after it has been written
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/rdy_vld_fifo_arb.sv
// rtl/rdy_vld_fifo_arb.sv - N-channel FIFO aggregator with RR/fixed arbitration; RDY_VLD_ARB_CNT_EN adds grant_cnt
module rdy_vld_fifo_arb
    import rdy_vld_arb_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 4,
    parameter int ARB_MODE = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    rdy_vld_fifo_arb_if.slave     bus
`ifdef RDY_VLD_ARB_CNT_EN
    ,
    output logic [N_CH*CNT_W-1:0] grant_cnt
`endif
);

    localparam int        CW   = CH_W(N_CH);
    localparam int        CNTW = $clog2(DEPTH) + 1;
    localparam arb_mode_e MODE = (ARB_MODE == 1) ? ARB_FIXED : ARB_RR;

    logic [N_CH-1:0]   push;
    logic [N_CH-1:0]   pop;
    logic [N_CH-1:0]   req;
    logic [N_CH-1:0]   full;
    logic [N_CH-1:0]   empty;
    logic [DATA_W-1:0] head  [N_CH];
    logic [CNTW-1:0]   count [N_CH];
    logic [CW-1:0]     last_grant;
    logic [CW-1:0]     gnt_ch;
    logic [CW-1:0]     cand;
    logic              gnt_vld;
    logic              stage_free;

    assign stage_free = !bus.out_vld || bus.out_rdy;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        rdy_vld_chan_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (push[i]),
            .pop       (pop[i]),
            .push_data (bus.in_data[i*DATA_W +: DATA_W]),
            .head      (head[i]),
            .count     (count[i]),
            .full      (full[i]),
            .empty     (empty[i])
        );
    end

    // Per-channel push, request and ready; ready never looks at in_vld or out_rdy
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            push[i]       = bus.in_vld[i] && !full[i];
            req[i]        = !empty[i];
            bus.in_rdy[i] = rst_n && (count[i] != CNTW'(DEPTH));
        end
    end

    // Arbiter: pick one non-empty channel whenever the output stage can take a word
    always_comb begin
        gnt_vld = 1'b0;
        gnt_ch  = '0;
        cand    = '0;
        if (stage_free) begin
            if (MODE == ARB_FIXED) begin
                for (int k = N_CH - 1; k >= 0; k--) begin
                    if (req[k]) begin
                        gnt_vld = 1'b1;
                        gnt_ch  = CW'(k);
                    end
                end
            end else begin
                // Walk backwards so the channel closest after last_grant wins
                for (int k = N_CH; k >= 1; k--) begin
                    cand = CW'((int'(last_grant) + k) % N_CH);
                    if (req[cand]) begin
                        gnt_vld = 1'b1;
                        gnt_ch  = cand;
                    end
                end
            end
        end
    end

    // Pop only the granted FIFO
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            pop[i] = gnt_vld && (gnt_ch == CW'(i));
        end
    end

    // Output stage: load on grant, clear when free and idle, hold while stalled
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.out_vld  <= 1'b0;
            bus.out_data <= '0;
            bus.out_ch   <= '0;
            last_grant   <= CW'(N_CH - 1);
        end else if (stage_free) begin
            bus.out_vld <= gnt_vld;
            if (gnt_vld) begin
                bus.out_data <= head[gnt_ch];
                bus.out_ch   <= gnt_ch;
                last_grant   <= gnt_ch;
            end
        end
    end

`ifdef RDY_VLD_ARB_CNT_EN
    // Completed output handshakes per source channel, wrapping at 2^32
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant_cnt <= '0;
        end else if (bus.out_vld && bus.out_rdy) begin
            grant_cnt[bus.out_ch*CNT_W +: CNT_W] <= grant_cnt[bus.out_ch*CNT_W +: CNT_W] + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_rdy_vld_fifo_arb.sv
// tb/tb_rdy_vld_fifo_arb.sv - self-checking bench for rdy_vld_fifo_arb (RR and fixed-priority instances)
module tb_rdy_vld_fifo_arb;

    localparam int N = 4;
    localparam int W = 32;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]   s_vld  = '0;
    logic [N*W-1:0] s_data = '0;
    logic           s_rdy  = 1'b0;

    int checks = 0;
    int errors = 0;

    rdy_vld_fifo_arb_if #(.N_CH(N), .DATA_W(W)) if_rr ();
    rdy_vld_fifo_arb_if #(.N_CH(N), .DATA_W(W)) if_fx ();

    assign if_rr.in_vld  = s_vld;
    assign if_rr.in_data = s_data;
    assign if_rr.out_rdy = s_rdy;
    assign if_fx.in_vld  = s_vld;
    assign if_fx.in_data = s_data;
    assign if_fx.out_rdy = s_rdy;

`ifdef RDY_VLD_ARB_CNT_EN
    logic [N*32-1:0] gc [2];
`endif

    rdy_vld_fifo_arb #(.N_CH(N), .DATA_W(W), .DEPTH(DEPTH), .ARB_MODE(0)) u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_rr)
`ifdef RDY_VLD_ARB_CNT_EN
        ,
        .grant_cnt (gc[0])
`endif
    );

    rdy_vld_fifo_arb #(.N_CH(N), .DATA_W(W), .DEPTH(DEPTH), .ARB_MODE(1)) u_fx (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_fx)
`ifdef RDY_VLD_ARB_CNT_EN
        ,
        .grant_cnt (gc[1])
`endif
    );

    logic [N-1:0]  o_rdy  [2];
    logic          o_vld  [2];
    logic [W-1:0]  o_data [2];
    logic [1:0]    o_ch   [2];
    assign o_rdy[0]  = if_rr.in_rdy;
    assign o_vld[0]  = if_rr.out_vld;
    assign o_data[0] = if_rr.out_data;
    assign o_ch[0]   = if_rr.out_ch;
    assign o_rdy[1]  = if_fx.in_rdy;
    assign o_vld[1]  = if_fx.out_vld;
    assign o_data[1] = if_fx.out_data;
    assign o_ch[1]   = if_fx.out_ch;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        repeat (n) step();
        rst_n = 1'b1;
    endtask

    // Reference model: queues per channel, one output slot, last winner for round-robin
    logic [W-1:0] mq [2][N][$];
    bit           m_vld  [2];
    logic [W-1:0] m_data [2];
    int           m_ch   [2];
    int           m_last [2];
    int unsigned  m_cnt  [2][N];
    bit           m_free;
    int           m_g;
    int           m_c;
    bit [N-1:0]   m_rdy_pre;
    logic [N-1:0] e_rdy;

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                for (int c = 0; c < N; c++) begin
                    mq[d][c].delete();
                    m_cnt[d][c] = 0;
                end
                m_vld[d]  = 1'b0;
                m_data[d] = '0;
                m_ch[d]   = 0;
                m_last[d] = N - 1;
            end else begin
                for (int c = 0; c < N; c++) m_rdy_pre[c] = (mq[d][c].size() != DEPTH);
                if (m_vld[d] && s_rdy) m_cnt[d][m_ch[d]] = m_cnt[d][m_ch[d]] + 1;
                m_free = !m_vld[d] || s_rdy;
                m_g = -1;
                if (m_free) begin
                    for (int k = 1; k <= N; k++) begin
                        m_c = (d == 1) ? (k - 1) : ((m_last[d] + k) % N);
                        if (m_g < 0 && mq[d][m_c].size() > 0) m_g = m_c;
                    end
                    if (m_g >= 0) begin
                        m_data[d] = mq[d][m_g].pop_front();
                        m_ch[d]   = m_g;
                        m_vld[d]  = 1'b1;
                        m_last[d] = m_g;
                    end else begin
                        m_vld[d] = 1'b0;
                    end
                end
                for (int c = 0; c < N; c++)
                    if (s_vld[c] && m_rdy_pre[c]) mq[d][c].push_back(s_data[c*W +: W]);
            end
        end
    end

    // Compare both instances against the model away from the active edge
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < N; c++) e_rdy[c] = rst_n && (mq[d][c].size() != DEPTH);
            chk($sformatf("model_in_rdy[%0d]", d), 64'(o_rdy[d]), 64'(e_rdy));
            chk($sformatf("model_out_vld[%0d]", d), 64'(o_vld[d]), 64'(m_vld[d]));
            if (m_vld[d]) begin
                chk($sformatf("model_out_data[%0d]", d), 64'(o_data[d]), 64'(m_data[d]));
                chk($sformatf("model_out_ch[%0d]", d), 64'(o_ch[d]), 64'(m_ch[d]));
            end
`ifdef RDY_VLD_ARB_CNT_EN
            for (int c = 0; c < N; c++)
                chk($sformatf("model_grant_cnt[%0d][%0d]", d, c), 64'(gc[d][c*32 +: 32]), 64'(m_cnt[d][c]));
`endif
        end
    end

    typedef struct {
        bit          rdy;
        bit          vld;
        int          rr_ch;
        logic [31:0] rr_d;
        int          fx_ch;
        logic [31:0] fx_d;
    } row_t;

    row_t tbl [9];
    int   acc;
    bit   r;

    initial begin
        tbl[0] = '{1, 1, 0, 32'h00, 0, 32'h00};
        tbl[1] = '{1, 1, 1, 32'h10, 0, 32'h01};
        tbl[2] = '{1, 1, 2, 32'h20, 1, 32'h10};
        tbl[3] = '{1, 1, 3, 32'h30, 1, 32'h11};
        tbl[4] = '{1, 1, 0, 32'h01, 2, 32'h20};
        tbl[5] = '{1, 1, 1, 32'h11, 2, 32'h21};
        tbl[6] = '{1, 1, 2, 32'h21, 3, 32'h30};
        tbl[7] = '{1, 1, 3, 32'h31, 3, 32'h31};
        tbl[8] = '{1, 0, 0, 32'h00, 0, 32'h00};

        // Reset state
        repeat (3) step();
        @(negedge clk);
        chk("rst_out_vld", 64'(o_vld[0]), 64'd0);
        chk("rst_out_data", 64'(o_data[0]), 64'd0);
        chk("rst_out_ch", 64'(o_ch[0]), 64'd0);
        chk("rst_in_rdy_low", 64'(o_rdy[0]), 64'd0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_in_rdy", 64'(o_rdy[0]), 64'hF);
        chk("rel_out_vld", 64'(o_vld[0]), 64'd0);

        // Reset mid-stream: three words on ch1, one in the output stage
        step();
        s_rdy = 1'b0;
        s_vld = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            s_data[1*W +: W] = 32'h5100 + k;
            step();
        end
        s_vld = '0;
        @(negedge clk);
        chk("mid_stage_loaded", 64'(o_vld[0]), 64'd1);
        step();
        do_reset(1);
        @(negedge clk);
        chk("mid_out_vld", 64'(o_vld[0]), 64'd0);
        chk("mid_in_rdy", 64'(o_rdy[0]), 64'hF);
        s_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            @(negedge clk);
            chk("mid_no_stale", 64'(o_vld[0]), 64'd0);
        end

        // Latency: push at edge t, visible after t+1, gone after t+2
        step();
        s_vld = 4'b0100;
        s_data[2*W +: W] = 32'hDEADBEEF;
        step();
        s_vld = '0;
        @(negedge clk);
        chk("lat_no_same_edge", 64'(o_vld[0]), 64'd0);
        step();
        @(negedge clk);
        chk("lat_vld", 64'(o_vld[0]), 64'd1);
        chk("lat_data", 64'(o_data[0]), 64'hDEADBEEF);
        chk("lat_ch", 64'(o_ch[0]), 64'd2);
        step();
        @(negedge clk);
        chk("lat_drained", 64'(o_vld[0]), 64'd0);

        // Full FIFO: five words accepted with the stage stalled
        step();
        s_rdy = 1'b0;
        s_vld = 4'b0001;
        acc = 0;
        for (int k = 0; k < 8; k++) begin
            s_data[0 +: W] = 32'hA0 + acc;
            @(negedge clk);
            r = o_rdy[0][0];
            step();
            if (r) acc++;
        end
        s_vld = '0;
        chk("full_accept_count", 64'(acc), 64'd5);
        @(negedge clk);
        chk("full_in_rdy0", 64'(o_rdy[0][0]), 64'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("full_hold_vld", 64'(o_vld[0]), 64'd1);
            chk("full_hold_data", 64'(o_data[0]), 64'hA0);
            chk("full_hold_ch", 64'(o_ch[0]), 64'd0);
            step();
        end
        s_rdy = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            step();
            @(negedge clk);
            chk("full_drain_data", 64'(o_data[0]), 64'(32'hA0 + j));
        end
        step();
        @(negedge clk);
        chk("full_drain_end", 64'(o_vld[0]), 64'd0);

        // Arbitration order: preload two words on every channel, then drain
        step();
        do_reset(1);
        s_rdy = 1'b0;
        s_vld = 4'hF;
        s_data = {32'h30, 32'h20, 32'h10, 32'h00};
        step();
        s_data = {32'h31, 32'h21, 32'h11, 32'h01};
        step();
        s_vld = '0;
        step();
        for (int i = 0; i < 9; i++) begin
            s_rdy = tbl[i].rdy;
            @(negedge clk);
            chk($sformatf("tbl_rr_vld[%0d]", i), 64'(o_vld[0]), 64'(tbl[i].vld));
            chk($sformatf("tbl_fx_vld[%0d]", i), 64'(o_vld[1]), 64'(tbl[i].vld));
            if (tbl[i].vld) begin
                chk($sformatf("tbl_rr_ch[%0d]", i), 64'(o_ch[0]), 64'(tbl[i].rr_ch));
                chk($sformatf("tbl_rr_data[%0d]", i), 64'(o_data[0]), 64'(tbl[i].rr_d));
                chk($sformatf("tbl_fx_ch[%0d]", i), 64'(o_ch[1]), 64'(tbl[i].fx_ch));
                chk($sformatf("tbl_fx_data[%0d]", i), 64'(o_data[1]), 64'(tbl[i].fx_d));
            end
            step();
        end

        // Random soak with one mid-run reset; the model checks every cycle
        for (int cyc = 0; cyc < 10000; cyc++) begin
            s_vld  = 4'($urandom);
            s_data = {$urandom, $urandom, $urandom, $urandom};
            s_rdy  = (cyc < 5000) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            rst_n  = (cyc != 6000);
            step();
        end
        rst_n = 1'b1;
        s_vld = '0;
        s_rdy = 1'b1;
        repeat (2 * N * DEPTH + 4) step();
        @(negedge clk);
        chk("soak_end_rr_vld", 64'(o_vld[0]), 64'd0);
        chk("soak_end_fx_vld", 64'(o_vld[1]), 64'd0);
        chk("soak_end_rr_rdy", 64'(o_rdy[0]), 64'hF);
        chk("soak_end_fx_rdy", 64'(o_rdy[1]), 64'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
